// File: rtl/kmeans_stream_host_pkg.sv
// Shared types and constants for the kMeans stream host: FSM states, error codes,
// default job geometry and the x/y field layout of a stream word.
package kmeans_pkg;

   localparam int unsigned CLUSTER_SIZE_DEF = 4;
   localparam int unsigned DATA_SIZE_DEF    = 4096;
   localparam int unsigned WORD_W           = 16;
   localparam int unsigned TMO_W            = 24;

   localparam int unsigned X_MSB = 15;
   localparam int unsigned X_LSB = 8;
   localparam int unsigned Y_MSB = 7;
   localparam int unsigned Y_LSB = 0;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_TIMEOUT = 2'd1,
      ERR_SHORT   = 2'd2,
      ERR_EARLY   = 2'd3
   } err_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SEND    = 3'd1,
      ST_FLUSH   = 3'd2,
      ST_WAIT    = 3'd3,
      ST_COLLECT = 3'd4
   } state_e;

endpackage

// File: rtl/kmeans_stream_host_if.sv
// Source-memory read port plus the accelerator in/out stream, bundled as one bus.
interface kmeans_stream_host_if #(
   parameter int unsigned ADDR_W = 13
) ();

   logic              src_rd;
   logic [ADDR_W-1:0] src_addr;
   logic [15:0]       src_rdata;
   logic              km_in_valid;
   logic [15:0]       km_in_data;
   logic              km_out_valid;
   logic [15:0]       km_out_data;

   modport master (
      output src_rd, src_addr, km_in_valid, km_in_data,
      input  src_rdata, km_out_valid, km_out_data
   );

   modport slave (
      input  src_rd, src_addr, km_in_valid, km_in_data,
      output src_rdata, km_out_valid, km_out_data
   );

endinterface

// File: rtl/kmeans_stream_host_src_reader.sv
// Walks source addresses 0..TOTAL-1 once per launch and turns the 1-cycle-latency
// read data into a gap-free registered valid/data stream.
module kmeans_src_reader
   import kmeans_pkg::*;
#(
   parameter int unsigned TOTAL  = 4100,
   parameter int unsigned ADDR_W = 13
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              launch_i,
   output logic              src_rd_o,
   output logic [ADDR_W-1:0] src_addr_o,
   input  logic [15:0]       src_rdata_i,
   output logic              km_in_valid_o,
   output logic [15:0]       km_in_data_o,
   output logic              issue_last_c_o,
   output logic              pipe_busy_c_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

   logic              rd_q, rd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rd_d1_q;
   logic              vld_q;
   logic [15:0]       data_q, data_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_q    <= 1'b0;
         addr_q  <= '0;
         rd_d1_q <= 1'b0;
         vld_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         rd_d1_q <= rd_q;
         vld_q   <= rd_d1_q;
         data_q  <= data_d;
      end
   end

   // Address holds at the last word once issued; only a new launch rewinds it.
   always_comb begin
      rd_d   = rd_q;
      addr_d = addr_q;
      if (launch_i) begin
         rd_d   = 1'b1;
         addr_d = '0;
      end else if (rd_q) begin
         if (addr_q == LAST_ADDR) rd_d   = 1'b0;
         else                     addr_d = addr_q + 1'b1;
      end
      data_d = rd_d1_q ? {src_rdata_i[X_MSB:X_LSB], src_rdata_i[Y_MSB:Y_LSB]} : 16'h0000;
   end

   assign src_rd_o       = rd_q;
   assign src_addr_o     = addr_q;
   assign km_in_valid_o  = vld_q;
   assign km_in_data_o   = data_q;
   assign issue_last_c_o = rd_q && (addr_q == LAST_ADDR);
   assign pipe_busy_c_o  = rd_q | rd_d1_q | vld_q;

endmodule

// File: rtl/kmeans_stream_host.sv
// Host side of the kMeans accelerator: streams centroids and points from source
// memory, then captures the result burst, reporting timeout and protocol errors.
module kmeans_stream_host
   import kmeans_pkg::*;
#(
   parameter int unsigned CLUSTER_SIZE   = CLUSTER_SIZE_DEF,
   parameter int unsigned DATA_SIZE      = DATA_SIZE_DEF,
   parameter int unsigned ADDR_W         = 13,
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   output logic                             busy,
   output logic                             done,
   output logic [1:0]                       err_code,
   output logic [WORD_W*CLUSTER_SIZE-1:0]   res_data,
   kmeans_stream_host_if.master             bus
);

   localparam int unsigned TOTAL  = CLUSTER_SIZE + DATA_SIZE;
   localparam int unsigned BEAT_W = $clog2(CLUSTER_SIZE) + 1;
   localparam int unsigned RES_W  = WORD_W * CLUSTER_SIZE;

   state_e             state_q, state_d;
   err_e               err_q, err_d;
   logic               done_q, done_d;
   logic               busy_q;
   logic [RES_W-1:0]   res_q, res_d;
   logic [BEAT_W-1:0]  beat_q, beat_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               launch_c;
   logic               issue_last_c;
   logic               pipe_busy_c;

   kmeans_src_reader #(
      .TOTAL  (TOTAL),
      .ADDR_W (ADDR_W)
   ) u_reader (
      .clk            (clk),
      .rst_n          (rst_n),
      .launch_i       (launch_c),
      .src_rd_o       (bus.src_rd),
      .src_addr_o     (bus.src_addr),
      .src_rdata_i    (bus.src_rdata),
      .km_in_valid_o  (bus.km_in_valid),
      .km_in_data_o   (bus.km_in_data),
      .issue_last_c_o (issue_last_c),
      .pipe_busy_c_o  (pipe_busy_c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         err_q   <= ERR_NONE;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         res_q   <= '0;
         beat_q  <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         done_q  <= done_d;
         busy_q  <= (state_d != ST_IDLE);
         res_q   <= res_d;
         beat_q  <= beat_d;
         tmo_q   <= tmo_d;
      end
   end

   // Job sequencing; result capture shares one path for WAIT (beat 0) and COLLECT.
   always_comb begin
      state_d  = state_q;
      err_d    = err_q;
      done_d   = 1'b0;
      res_d    = res_q;
      beat_d   = beat_q;
      tmo_d    = tmo_q;
      launch_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               launch_c = 1'b1;
               err_d    = ERR_NONE;
               state_d  = ST_SEND;
            end
         end
         ST_SEND: begin
            if (bus.km_out_valid) err_d = ERR_EARLY;
            if (issue_last_c) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (bus.km_out_valid) err_d = ERR_EARLY;
            if (!pipe_busy_c) begin
               state_d = ST_WAIT;
               tmo_d   = '0;
               beat_d  = '0;
            end
         end
         ST_WAIT, ST_COLLECT: begin
            if (bus.km_out_valid) begin
               for (int k = 0; k < CLUSTER_SIZE; k++) begin
                  if (beat_q == BEAT_W'(k)) res_d[WORD_W*k +: WORD_W] = bus.km_out_data;
               end
               if (beat_q == BEAT_W'(CLUSTER_SIZE - 1)) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  beat_d  = beat_q + 1'b1;
                  state_d = ST_COLLECT;
               end
            end else if (state_q == ST_COLLECT) begin
               err_d   = ERR_SHORT;
               state_d = ST_IDLE;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               err_d   = ERR_TIMEOUT;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign err_code = err_q;
   assign res_data = res_q;

endmodule

// File: tb/tb_kmeans_stream_host.sv
// Directed bench for kmeans_stream_host: stream monitor against the source image,
// scripted accelerator responses, and literal checks of results and error codes.
module tb_kmeans_stream_host;

   localparam int unsigned CS     = 4;
   localparam int unsigned DS     = 4096;
   localparam int unsigned AW     = 13;
   localparam int unsigned TMO    = 100;
   localparam int unsigned TOTAL  = CS + DS;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start;
   logic        busy;
   logic        done;
   logic [1:0]  err_code;
   logic [63:0] res_data;

   kmeans_stream_host_if #(.ADDR_W(AW)) bus ();

   kmeans_stream_host #(
      .CLUSTER_SIZE   (CS),
      .DATA_SIZE      (DS),
      .ADDR_W         (AW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .err_code (err_code),
      .res_data (res_data),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [0:TOTAL-1];
   logic [15:0] beats [4];
   int cyc = 0;
   int vectors = 0;
   int fails = 0;
   int widx = 0;
   int bursts = 0;
   int exp_len = TOTAL;
   int exp_first = 0;
   int last_cyc = 0;
   int have_prev = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int last_beat_cyc = 0;
   logic [15:0] first_word, last_word;

   localparam logic [63:0] R_NOM = 64'hE0E0_E020_20E0_2020;

   initial begin
      mem[0] = 16'h1010; mem[1] = 16'h10F0; mem[2] = 16'hF010; mem[3] = 16'hF0F0;
      for (int a = 4; a < TOTAL; a++) mem[a] = 16'(a) ^ 16'h5A5A;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Source memory: data appears the cycle after the read strobe.
   always @(posedge clk) if (bus.src_rd) bus.src_rdata <= mem[bus.src_addr];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Stream monitor: every cycle the stream must match the source image or be zero.
   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bus.km_in_valid) begin
         if (widx == 0) begin
            if (have_prev != 0) chk("gap", 64'(cyc - last_cyc >= 2), 64'd1);
            chk("first_cycle", 64'(cyc), 64'(exp_first));
            first_word = bus.km_in_data;
         end
         if (widx < TOTAL) chk("word", 64'(bus.km_in_data), 64'(mem[widx]));
         else              chk("overrun", 64'(widx), 64'(TOTAL - 1));
         last_word = bus.km_in_data;
         last_cyc  = cyc;
         widx++;
      end else begin
         chk("idle_data", 64'(bus.km_in_data), 64'd0);
         if (widx != 0) begin
            chk("burst_len", 64'(widx), 64'(exp_len));
            bursts++;
            have_prev = 1;
            widx = 0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      exp_first = cyc + 3;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_widx(input int n);
      int k = 0;
      while (widx < n && k < 6000) begin
         tick(1);
         k++;
      end
      chk("wait_widx", 64'(widx >= n), 64'd1);
   endtask

   task automatic wait_burst(input int target);
      int k = 0;
      while (bursts < target && k < 6000) begin
         tick(1);
         k++;
      end
      chk("burst_count", 64'(bursts), 64'(target));
   endtask

   task automatic drive_beats(input int n);
      for (int i = 0; i < n; i++) begin
         bus.km_out_valid = 1'b1;
         bus.km_out_data  = beats[i];
         last_beat_cyc    = cyc;
         tick(1);
      end
      bus.km_out_valid = 1'b0;
      bus.km_out_data  = 16'h0000;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      start = 1'b0;
      bus.km_out_valid = 1'b0;
      bus.km_out_data  = 16'h0000;
      tick(3);
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_done",  64'(done), 64'd0);
      chk("rst_err",   64'(err_code), 64'd0);
      chk("rst_rd",    64'(bus.src_rd), 64'd0);
      chk("rst_addr",  64'(bus.src_addr), 64'd0);
      chk("rst_valid", 64'(bus.km_in_valid), 64'd0);
      chk("rst_res",   res_data, 64'd0);
      rst_n = 1'b1;
      tick(2);

      // Nominal job
      pulse_start();
      wait_widx(2000);
      chk("busy_send", 64'(busy), 64'd1);
      wait_burst(1);
      chk("first_word", 64'(first_word), 64'h1010);
      chk("last_word",  64'(last_word),  64'h4A59);
      chk("addr_hold",  64'(bus.src_addr), 64'd4099);
      chk("rd_off",     64'(bus.src_rd), 64'd0);
      tick(3);
      beats = '{16'h2020, 16'h20E0, 16'hE020, 16'hE0E0};
      drive_beats(4);
      chk("done_cyc", 64'(done_cyc), 64'(last_beat_cyc + 1));
      tick(2);
      chk("nom_done", 64'(done_cnt), 64'd1);
      chk("nom_res",  res_data, R_NOM);
      chk("nom_err",  64'(err_code), 64'd0);
      chk("nom_busy", 64'(busy), 64'd0);

      // Ignored start during SEND plus an early out_valid pulse
      pulse_start();
      wait_widx(500);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_widx(1000);
      bus.km_out_valid = 1'b1;
      bus.km_out_data  = 16'hDEAD;
      tick(1);
      bus.km_out_valid = 1'b0;
      bus.km_out_data  = 16'h0000;
      wait_burst(2);
      chk("early_err", 64'(err_code), 64'd3);
      tick(3);
      beats = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
      drive_beats(4);
      tick(2);
      chk("early_done", 64'(done_cnt), 64'd2);
      chk("early_res",  res_data, 64'h0708_0506_0304_0102);
      chk("early_sticky", 64'(err_code), 64'd3);

      // Back-to-back job right after done
      pulse_start();
      wait_burst(3);
      tick(3);
      beats = '{16'h2020, 16'h20E0, 16'hE020, 16'hE0E0};
      drive_beats(4);
      tick(2);
      chk("b2b_done", 64'(done_cnt), 64'd3);
      chk("b2b_err",  64'(err_code), 64'd0);
      chk("b2b_res",  res_data, R_NOM);

      // Timeout: accelerator stays silent
      pulse_start();
      wait_burst(4);
      tick(49);
      chk("tmo_pre_busy", 64'(busy), 64'd1);
      chk("tmo_pre_err",  64'(err_code), 64'd0);
      n = 0;
      while (busy && n < 400) begin
         tick(1);
         n++;
      end
      chk("tmo_cycle", 64'(cyc), 64'(last_cyc + 2 + TMO));
      chk("tmo_err",   64'(err_code), 64'd1);
      tick(3);
      chk("tmo_nodone", 64'(done_cnt), 64'd3);
      chk("tmo_res",    res_data, R_NOM);

      // Short result burst
      pulse_start();
      wait_burst(5);
      tick(3);
      beats = '{16'h1111, 16'h2222, 16'h0000, 16'h0000};
      drive_beats(2);
      tick(1);
      chk("short_err",  64'(err_code), 64'd2);
      chk("short_busy", 64'(busy), 64'd0);
      tick(2);
      chk("short_nodone", 64'(done_cnt), 64'd3);
      chk("short_res",    res_data, 64'hE0E0_E020_2222_1111);

      // Reset in the middle of the stream, then restart
      pulse_start();
      wait_widx(2000);
      exp_len = 2000;
      rst_n = 1'b0;
      tick(1);
      chk("mid_valid", 64'(bus.km_in_valid), 64'd0);
      chk("mid_busy",  64'(busy), 64'd0);
      chk("mid_res",   res_data, 64'd0);
      chk("mid_err",   64'(err_code), 64'd0);
      chk("mid_rd",    64'(bus.src_rd), 64'd0);
      rst_n = 1'b1;
      chk("mid_abort", 64'(bursts), 64'd6);
      exp_len = TOTAL;
      tick(2);
      pulse_start();
      wait_burst(7);
      chk("restart_first", 64'(first_word), 64'h1010);
      tick(3);
      beats = '{16'h2020, 16'h20E0, 16'hE020, 16'hE0E0};
      drive_beats(4);
      tick(2);
      chk("restart_done", 64'(done_cnt), 64'd4);
      chk("restart_res",  res_data, R_NOM);
      chk("restart_err",  64'(err_code), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
